// File: rtl/dm_bank_ctrl.sv
// ---------------------------------------------------------------------------
// dm_bank_ctrl
//   Word-organised data memory bank with per-byte write enables and a
//   request/ready handshake with a programmable number of wait states.
//   Receives lane-positioned write data and a 4-bit byte enable from
//   dm_control, and returns the raw 32-bit word for load slicing.
//
//   Optional feature macro: DM_RANGE_CHECK_EN
//     defined   : out-of-range accesses do not write, read back 0, and pulse
//                 err together with ready.
//     undefined : err is tied low and the word index wraps modulo DEPTH_WORDS.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_BASE    byte address of word 0 (aligned to DEPTH_WORDS*4)
//   WAIT_STATES  extra cycles per access before ready (0..15)
//
// Ports
//   clk    in   system clock, rising edge
//   rstn   in   asynchronous active-low reset
//   req    in   access request, sampled only when idle
//   mem_w  in   1 = write, 0 = read
//   addr   in   byte address, addr[1:0] ignored
//   wea    in   byte-lane write enable, bit i -> wdata[8i+7:8i]
//   wdata  in   lane-positioned write data
//   rdata  out  registered read word
//   ready  out  one-cycle completion pulse
//   busy   out  high from accept through the ready cycle
//   err    out  out-of-range flag, pulses with ready
// ---------------------------------------------------------------------------
module dm_bank_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [3:0]  wea,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic            mem_w_q;
  logic [AW-1:0]   idx_q;
  logic [3:0]      wea_q;
  logic [31:0]     wdata_q;
  logic            oor_q;

  logic [31:0]     mem [DEPTH_WORDS];

  // Decode of the incoming request address.
  logic [31:0]     off;
  logic [AW-1:0]   idx_in;
  logic            oor_in;
  logic            unused_off_bits;

  assign off             = addr - ADDR_BASE;
  assign idx_in          = off[AW+1:2];
  assign unused_off_bits = ^{off[31:AW+2], off[1:0]};

`ifdef DM_RANGE_CHECK_EN
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  assign oor_in = (addr < ADDR_BASE) || ({1'b0, off} >= LIMIT);
`else
  assign oor_in = 1'b0;
`endif

  // With zero wait states the commit edge is the accept edge itself, so the
  // access fields come straight from the inputs while idle and from the
  // captured copies otherwise.
  logic            acc_w;
  logic [AW-1:0]   acc_idx;
  logic [3:0]      acc_wea;
  logic [31:0]     acc_wdata;
  logic            acc_oor;
  logic            commit;

  assign acc_w     = (state == S_IDLE) ? mem_w  : mem_w_q;
  assign acc_idx   = (state == S_IDLE) ? idx_in : idx_q;
  assign acc_wea   = (state == S_IDLE) ? wea    : wea_q;
  assign acc_wdata = (state == S_IDLE) ? wdata  : wdata_q;
  assign acc_oor   = (state == S_IDLE) ? oor_in : oor_q;
  assign commit    = (state_next == S_RESP);

  // State register, wait counter and request capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_w_q <= 1'b0;
      idx_q   <= '0;
      wea_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req) begin
        cnt     <= '0;
        mem_w_q <= mem_w;
        idx_q   <= idx_in;
        wea_q   <= wea;
        wdata_q <= wdata;
        oor_q   <= oor_in;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Next-state logic. WAIT is left once the cycle being spent there is the
  // WAIT_STATES-th one.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (({1'b0, cnt} + 5'd1) >= 5'(WAIT_STATES)) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    err   = 1'b0;
    case (state)
      S_WAIT: busy = 1'b1;
      S_RESP: begin
        ready = 1'b1;
        busy  = 1'b1;
`ifdef DM_RANGE_CHECK_EN
        err   = oor_q;
`endif
      end
      default: ;
    endcase
  end

  // Array write on the edge entering RESP. Holding reset blocks the commit so
  // an aborted access can never land in the array.
  // NOTE: the array has no reset; contents survive rstn by design.
  always_ff @(posedge clk) begin
    if (rstn && commit && acc_w && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wea[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Read word register: only completed reads update it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (commit && !acc_w) begin
      rdata <= acc_oor ? 32'h0 : mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_dm_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_bank_ctrl
//   Directed bench for dm_bank_ctrl. Three instances share the request bus:
//   WAIT_STATES = 1 (main), 0 and 15, so every access also exercises the
//   latency extremes.
// ---------------------------------------------------------------------------
module tb_dm_bank_ctrl;

  logic        clk;
  logic        rstn;
  logic        req;
  logic        mem_w;
  logic [31:0] addr;
  logic [3:0]  wea;
  logic [31:0] wdata;

  logic [31:0] rdata, rdata_w0, rdata_w15;
  logic        ready, ready_w0, ready_w15;
  logic        busy, busy_w0, busy_w15;
  logic        err, err_w0, err_w15;

  int n_cmp = 0;
  int n_bad = 0;

  int   lat_m, lat0, lat15;
  logic err_m;

  dm_bank_ctrl #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(1)) dut (
    .clk(clk), .rstn(rstn), .req(req), .mem_w(mem_w), .addr(addr), .wea(wea),
    .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  dm_bank_ctrl #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .rstn(rstn), .req(req), .mem_w(mem_w), .addr(addr), .wea(wea),
    .wdata(wdata), .rdata(rdata_w0), .ready(ready_w0), .busy(busy_w0), .err(err_w0)
  );

  dm_bank_ctrl #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(15)) dut_w15 (
    .clk(clk), .rstn(rstn), .req(req), .mem_w(mem_w), .addr(addr), .wea(wea),
    .wdata(wdata), .rdata(rdata_w15), .ready(ready_w15), .busy(busy_w15), .err(err_w15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the shared bus. Latency is counted in cycles after the
  // request cycle: 1 means ready is high right after the accept edge.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; mem_w = w; addr = a; wea = we; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat_m = 0; lat0 = 0; lat15 = 0; err_m = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (ready && lat_m == 0) begin
        lat_m = n + 1;
        err_m = err;
      end
      if (ready_w0 && lat0 == 0) lat0 = n + 1;
      if (ready_w15 && lat15 == 0) lat15 = n + 1;
      if (lat_m != 0 && lat0 != 0 && lat15 != 0) break;
      @(posedge clk); #1;
    end
    check("latency_ws1", lat_m, 2);
    check("latency_ws0", lat0, 1);
    check("latency_ws15", lat15, 16);
    @(posedge clk); #1;
    check("busy_drop_ws1", {31'b0, busy}, 0);
    check("busy_drop_ws15", {31'b0, busy_w15}, 0);
  endtask

  int pos[3];
  int np;
  int nr;

  initial begin
    rstn = 1'b0; req = 1'b0; mem_w = 1'b0; addr = '0; wea = '0; wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_err", {31'b0, err}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Full-word write and read back
    access(1'b1, 32'h20, 4'b1111, 32'h1234_5678);
    access(1'b0, 32'h20, 4'b1111, 32'h0);
    check("rd20_ws1", rdata, 32'h1234_5678);
    check("rd20_ws0", rdata_w0, 32'h1234_5678);
    check("rd20_ws15", rdata_w15, 32'h1234_5678);

    // Reset in the middle of a write wait state
    access(1'b1, 32'h10, 4'b1111, 32'h1122_3344);
    @(negedge clk);
    req = 1'b1; mem_w = 1'b1; addr = 32'h10; wea = 4'b1111; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    check("mid_busy_ws1", {31'b0, busy}, 1);
    check("mid_busy_ws15", {31'b0, busy_w15}, 1);
    rstn = 1'b0;
    #1;
    check("abort_rdata", rdata, 32'h0);
    check("abort_ready", {31'b0, ready}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_err", {31'b0, err}, 0);
    check("abort_busy_ws15", {31'b0, busy_w15}, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    access(1'b0, 32'h10, 4'b1111, 32'h0);
    check("rd10_after_abort", rdata, 32'h1122_3344);
    check("rd10_after_abort_ws15", rdata_w15, 32'h1122_3344);

    // Byte-lane merge and empty-enable write
    access(1'b1, 32'h24, 4'b1111, 32'hAABB_CCDD);
    access(1'b1, 32'h24, 4'b0100, 32'h00EE_0000);
    access(1'b0, 32'h24, 4'b0000, 32'h0);
    check("merge_lane2", rdata, 32'hAAEE_CCDD);
    access(1'b1, 32'h24, 4'b0000, 32'hFFFF_FFFF);
    check("rdata_held_over_write", rdata, 32'hAAEE_CCDD);
    access(1'b0, 32'h24, 4'b1111, 32'h0);
    check("wea0_no_change", rdata, 32'hAAEE_CCDD);
    check("wea0_no_change_ws0", rdata_w0, 32'hAAEE_CCDD);

    // Back-to-back reads with req held high
    @(negedge clk);
    req = 1'b1; mem_w = 1'b0; addr = 32'h20; wea = 4'b0000;
    np = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (ready) begin
        pos[np] = n;
        np++;
        if (np == 3) begin
          req = 1'b0;
          break;
        end
      end
    end
    check("b2b_count", np, 3);
    check("b2b_first", pos[0], 1);
    check("b2b_gap1", pos[1] - pos[0], 3);
    check("b2b_gap2", pos[2] - pos[1], 3);
    check("b2b_rdata", rdata, 32'h1234_5678);
    repeat (25) @(posedge clk);

    // Request pulses while busy are dropped
    @(negedge clk);
    req = 1'b1; mem_w = 1'b0; addr = 32'h24;
    @(posedge clk); #1;
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ready) nr++;
      if (k == 1) req = 1'b0;
    end
    check("busy_req_ignored", nr, 1);
    check("busy_req_idle", {31'b0, busy}, 0);
    check("busy_req_rdata", rdata, 32'hAAEE_CCDD);
    repeat (25) @(posedge clk);

    // Address one past the top of the bank
    access(1'b1, 32'h0, 4'b1111, 32'hCAFE_F00D);
    access(1'b1, 32'h1000, 4'b1111, 32'h0000_0001);
`ifdef DM_RANGE_CHECK_EN
    check("range_wr_err", {31'b0, err_m}, 1);
`else
    check("range_wr_err", {31'b0, err_m}, 0);
`endif
    access(1'b0, 32'h1000, 4'b1111, 32'h0);
`ifdef DM_RANGE_CHECK_EN
    check("range_rd_err", {31'b0, err_m}, 1);
    check("range_rd_data", rdata, 32'h0);
`else
    check("range_rd_err", {31'b0, err_m}, 0);
    check("range_rd_data", rdata, 32'h0000_0001);
`endif
    access(1'b0, 32'h0, 4'b1111, 32'h0);
    check("word0_err", {31'b0, err_m}, 0);
`ifdef DM_RANGE_CHECK_EN
    check("word0_data", rdata, 32'hCAFE_F00D);
`else
    check("word0_data", rdata, 32'h0000_0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
